// File: rtl/des_pkg.sv
// Shared DES tables, state type and combinational helper functions for the
// iterative DES engine. Bit numbering follows DES: bit 1 is the MSB.
package des_pkg;

    localparam int NUM_ROUNDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } des_state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int SBOX_T [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    // Encrypt rotates left; decrypt walks the schedule backwards, so its
    // first round uses the unrotated C0/D0 (which equal C16/D16).
    localparam logic [1:0] LSHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [1:0] RSHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    // Each 6-bit group selects row {b1,b6} and column b2..b5; S1 lands in the top nibble.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [47:0] t;
        logic [5:0]  six;
        y = '0;
        t = x;
        for (int k = 0; k < 8; k++) begin
            six = t[47:42];
            t   = t << 6;
            y   = {y[27:0], 4'(SBOX_T[3'(k)][{six[5], six[0], six[4:1]}])};
        end
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expand, mix with the round key, S-box, permute.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    // Purely combinational round function.
    always_comb begin
        f_o = p_perm(sbox_sub(e_expand(r_i) ^ k_i));
    end

endmodule

// File: rtl/des_key_step.sv
// One key-schedule step: rotate C/D for the current round and derive Ki.
module des_key_step
    import des_pkg::*;
(
    input  logic [27:0] c_i,
    input  logic [27:0] d_i,
    input  logic        decrypt_i,
    input  logic [4:0]  rnd_i,
    output logic [27:0] c_o,
    output logic [27:0] d_o,
    output logic [47:0] k_o
);

    logic [3:0]  idx;
    logic [1:0]  amt;
    logic [27:0] c_rot;
    logic [27:0] d_rot;

    // Rounds are numbered 1..16; table index is rnd-1.
    always_comb begin
        idx = 4'(rnd_i - 5'd1);
        amt = decrypt_i ? RSHIFT[idx] : LSHIFT[idx];
        if (decrypt_i) begin
            c_rot = rotr28(c_i, amt);
            d_rot = rotr28(d_i, amt);
        end else begin
            c_rot = rotl28(c_i, amt);
            d_rot = rotl28(d_i, amt);
        end
        c_o = c_rot;
        d_o = d_rot;
        k_o = pc2_perm({c_rot, d_rot});
    end

endmodule

// File: rtl/des_iter_engine.sv
// Iterative DES engine: one shared round and key step reused for 16 cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | in_ready high; accept loads IP(block) and PC1(key)
// ST_ROUND | one Feistel round per clock, rnd = 1..16
// ST_DONE  | result held on out_block until out_ready
module des_iter_engine
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [64:1] in_block,
    input  logic [64:1] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_block,
    output logic        busy
);

    des_state_e  state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  rnd_q, rnd_d;
    logic        mode_q, mode_d;
    logic [64:1] out_q, out_d;

    logic [63:0] lr0;
    logic [55:0] cd0;
    logic [27:0] c_nxt, d_nxt;
    logic [47:0] k_rnd;
    logic [31:0] f_out;

    assign lr0 = ip_perm(in_block);
    assign cd0 = pc1_perm(in_key);

    des_key_step u_key_step (
        .c_i       (c_q),
        .d_i       (d_q),
        .decrypt_i (mode_q),
        .rnd_i     (rnd_q),
        .c_o       (c_nxt),
        .d_o       (d_nxt),
        .k_o       (k_rnd)
    );

    des_f u_f (
        .r_i (r_q),
        .k_i (k_rnd),
        .f_o (f_out)
    );

    // Next-state and datapath selection; everything holds unless updated.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = lr0[63:32];
                    r_d     = lr0[31:0];
                    c_d     = cd0[55:28];
                    d_d     = cd0[27:0];
                    mode_d  = in_decrypt;
                    rnd_d   = 5'd1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                c_d   = c_nxt;
                d_d   = d_nxt;
                rnd_d = rnd_q + 5'd1;
                if (rnd_q == 5'(NUM_ROUNDS)) begin
                    // Final swap: output is FP(R16 || L16).
                    out_d   = fp_perm({l_q ^ f_out, r_q});
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_block = out_q;

endmodule
